// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
//
// Purpose:
//   Serialises a stereo sample pair into a standard I2S stream for the audio
//   DAC. Runs entirely in the audio_mclk domain. SCLK and LRCK are divided
//   down from MCLK. One coherent L/R pair is captured per frame, at the
//   frame boundary. Each channel is then shifted out MSB-first, with the
//   usual I2S one-bit delay after the LRCK edge.
//
// Parameters:
//   DATA_W        - sample width per channel (must be <= SLOT_W-1)
//   SLOT_W        - SCLK periods per channel slot; a frame is 2*SLOT_W
//   MCLK_PER_SCLK - MCLK cycles per SCLK period (even, >= 2)
//
// Ports:
//   audio_mclk  in   sole clock (audio master clock)
//   reset       in   synchronous, active-high reset
//   audio_l     in   left sample  [DATA_W-1:0]
//   audio_r     in   right sample [DATA_W-1:0]
//   audio_sclk  out  bit clock, MCLK/MCLK_PER_SCLK, 50% duty
//   audio_lrck  out  word select, 0 = left slot, 1 = right slot
//   audio_dac   out  serial data, updates on the SCLK falling edge
//   frame_start out  one-MCLK pulse when a new L/R pair has been captured
//
// Optional feature:
//   AUDIO_TX_OFFSET_BINARY_EN - when defined, inputs are offset-binary and
//   their MSB is inverted at capture. When undefined, samples are sent
//   bit-exact as two's complement. Timing is identical in both builds.
// -----------------------------------------------------------------------------
module audio_i2s_tx #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned SLOT_W        = 32,
    parameter int unsigned MCLK_PER_SCLK = 4
) (
    input  logic              audio_mclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] audio_l,
    input  logic [DATA_W-1:0] audio_r,
    output logic              audio_sclk,
    output logic              audio_lrck,
    output logic              audio_dac,
    output logic              frame_start
);

    localparam int unsigned DIV_W = (MCLK_PER_SCLK > 2) ? $clog2(MCLK_PER_SCLK) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DivLast       = DIV_W'(MCLK_PER_SCLK - 1);
    localparam logic [DIV_W-1:0] DivHalf       = DIV_W'(MCLK_PER_SCLK / 2);
    localparam logic [BIT_W-1:0] BitLast       = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] RightStart    = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] LeftDataLast  = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] RightDataLast = BIT_W'(SLOT_W + DATA_W);

    // Elaboration-time sanity checks on the configuration.
    if (DATA_W < 2 || DATA_W > SLOT_W - 1) begin : g_bad_data_w
        $error("audio_i2s_tx: DATA_W must be in 2..SLOT_W-1");
    end
    if (MCLK_PER_SCLK < 2 || (MCLK_PER_SCLK % 2) != 0) begin : g_bad_div
        $error("audio_i2s_tx: MCLK_PER_SCLK must be even and >= 2");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sclk_q, sclk_d;
    logic              lrck_q, lrck_d;
    logic              dac_q, dac_d;
    logic              frame_start_q, frame_start_d;
    logic [DATA_W-1:0] shift_l_q, shift_l_d;
    logic [DATA_W-1:0] shift_r_q, shift_r_d;

    // -------------------------------------------------------------------------
    // Capture formatting
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] cap_l, cap_r;

`ifdef AUDIO_TX_OFFSET_BINARY_EN
    // Offset-binary to two's complement: flip the sign bit only.
    assign cap_l = {~audio_l[DATA_W-1], audio_l[DATA_W-2:0]};
    assign cap_r = {~audio_r[DATA_W-1], audio_r[DATA_W-2:0]};
`else
    assign cap_l = audio_l;
    assign cap_r = audio_r;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic sclk_fall;
    logic frame_wrap;
    logic left_slot;
    logic right_slot;

    always_comb begin
        sclk_fall  = (div_cnt_q == DivLast);
        frame_wrap = sclk_fall && (bit_cnt_q == BitLast);

        div_cnt_d = sclk_fall ? '0 : div_cnt_q + 1'b1;
        // Registered from the next divider value, so audio_sclk is high
        // exactly while div_cnt_q is in the upper half.
        sclk_d    = (div_cnt_d >= DivHalf);

        bit_cnt_d = bit_cnt_q;
        if (sclk_fall) begin
            bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
        end

        // Slot decode uses the new bit count, i.e. the bit about to be driven.
        left_slot  = (bit_cnt_d != '0) && (bit_cnt_d <= LeftDataLast);
        right_slot = (bit_cnt_d > RightStart) && (bit_cnt_d <= RightDataLast);

        lrck_d        = lrck_q;
        dac_d         = dac_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        frame_start_d = frame_wrap;

        if (sclk_fall) begin
            lrck_d = (bit_cnt_d >= RightStart);
            dac_d  = 1'b0;
            if (left_slot) begin
                dac_d     = shift_l_q[DATA_W-1];
                shift_l_d = {shift_l_q[DATA_W-2:0], 1'b0};
            end
            if (right_slot) begin
                dac_d     = shift_r_q[DATA_W-1];
                shift_r_d = {shift_r_q[DATA_W-2:0], 1'b0};
            end
        end

        // Capture happens at bit_cnt 0, which is never a data slot, so it
        // cannot collide with a shift.
        if (frame_wrap) begin
            shift_l_d = cap_l;
            shift_r_d = cap_r;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge audio_mclk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            sclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            dac_q         <= 1'b0;
            frame_start_q <= 1'b0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sclk_q        <= sclk_d;
            lrck_q        <= lrck_d;
            dac_q         <= dac_d;
            frame_start_q <= frame_start_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
        end
    end

    assign audio_sclk  = sclk_q;
    assign audio_lrck  = lrck_q;
    assign audio_dac   = dac_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] audio_l = 16'h0000;
    logic [15:0] audio_r = 16'h0000;
    logic        audio_sclk, audio_lrck, audio_dac, frame_start;

    int n_pass  = 0;
    int n_total = 0;

    audio_i2s_tx dut (
        .audio_mclk  (mclk),
        .reset       (reset),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .audio_sclk  (audio_sclk),
        .audio_lrck  (audio_lrck),
        .audio_dac   (audio_dac),
        .frame_start (frame_start)
    );

    always #5 mclk = ~mclk;

    // Background monitor: audio_dac may only change with an SCLK falling edge,
    // and frame_start must recur every 256 MCLK outside of reset.
    int   dac_bad = 0;
    int   fs_bad  = 0;
    int   mon_cyc = 0;
    int   last_fs = -1;
    logic dac_p   = 1'b0;
    logic sclk_p  = 1'b0;
    logic rst_p   = 1'b1;

    always @(posedge mclk) begin
        if (rst_p) begin
            last_fs <= -1;
        end else begin
            if (audio_dac !== dac_p && !(sclk_p === 1'b1 && audio_sclk === 1'b0))
                dac_bad <= dac_bad + 1;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0 && mon_cyc - last_fs != 256) fs_bad <= fs_bad + 1;
                last_fs <= mon_cyc;
            end
        end
        dac_p   <= audio_dac;
        sclk_p  <= audio_sclk;
        rst_p   <= reset;
        mon_cyc <= mon_cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] ob(input logic [15:0] x);
`ifdef AUDIO_TX_OFFSET_BINARY_EN
        return {~x[15], x[14:0]};
`else
        return x;
`endif
    endfunction

    // Expected dac bits per SCLK slot n (bit n of the vector).
    function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            v[1 + i]  = l[15 - i];
            v[33 + i] = r[15 - i];
        end
        return v;
    endfunction

    localparam logic [63:0] LrckExp = {{32{1'b1}}, {32{1'b0}}};

    // Called on the negedge after the reset posedge (k = 0). Checks the first
    // 256 MCLK of waveform and returns on the negedge where frame_start is high.
    task automatic frame0_check(input string tag);
        int sclk_err = 0;
        int lrck_err = 0;
        int dac_err  = 0;
        int fs_err   = 0;
        for (int k = 1; k < 256; k++) begin
            @(negedge mclk);
            if (audio_sclk !== ((k % 4) >= 2)) sclk_err++;
            if (audio_lrck !== (k >= 128)) lrck_err++;
            if (audio_dac !== 1'b0) dac_err++;
            if (frame_start !== 1'b0) fs_err++;
        end
        @(negedge mclk);
        check({tag, "_sclk_wave"}, 64'(sclk_err), 64'd0);
        check({tag, "_lrck_wave"}, 64'(lrck_err), 64'd0);
        check({tag, "_frame0_dac_zero"}, 64'(dac_err), 64'd0);
        check({tag, "_no_early_fs"}, 64'(fs_err), 64'd0);
        check({tag, "_fs_at_256"}, 64'(frame_start), 64'd1);
    endtask

    // Waits for the frame_start negedge. rnd: randomise audio_l every cycle.
    // cap_l returns the audio_l value sampled at the capture edge.
    task automatic wait_fs(input bit rnd, output logic [15:0] cap_l);
        logic [15:0] prev;
        bit found = 0;
        prev = audio_l;
        cap_l = 'x;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge mclk);
            if (frame_start === 1'b1) begin
                found = 1;
                cap_l = prev;
            end else begin
                if (rnd) audio_l = 16'($urandom);
                prev = audio_l;
            end
        end
        check("frame_start_seen", 64'(found), 64'd1);
    endtask

    // Starts on a frame_start negedge; samples dac/lrck on 64 SCLK rises.
    // mode 1: set audio_l = chg_l chg_cyc MCLK later; mode 2: random every MCLK.
    task automatic capture_frame(input int mode, input int chg_cyc, input logic [15:0] chg_l,
                                 output logic [63:0] d, output logic [63:0] lr);
        int   rises = 0;
        logic ps;
        int   fs_wide = 0;
        ps = audio_sclk;
        d  = '0;
        lr = '0;
        for (int cyc = 1; cyc < 400 && rises < 64; cyc++) begin
            @(negedge mclk);
            if (frame_start !== 1'b0) fs_wide++;
            if (mode == 1 && cyc == chg_cyc) audio_l = chg_l;
            if (mode == 2) audio_l = 16'($urandom);
            if (!ps && audio_sclk) begin
                d[rises]  = audio_dac;
                lr[rises] = audio_lrck;
                rises++;
            end
            ps = audio_sclk;
        end
        check("sclk_rises_in_frame", 64'(rises), 64'd64);
        check("frame_start_one_cycle", 64'(fs_wide), 64'd0);
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] el;  // expected, two's-complement view
        logic [15:0] er;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0] d, lr;
        logic [15:0] cap;

        vecs[0] = '{l: 16'hA5C3, r: 16'h1234, el: 16'hA5C3, er: 16'h1234};
        vecs[1] = '{l: 16'h8000, r: 16'h0000, el: 16'h8000, er: 16'h0000};
        vecs[2] = '{l: 16'hFFFF, r: 16'h0000, el: 16'hFFFF, er: 16'h0000};
        vecs[3] = '{l: 16'h0001, r: 16'h8001, el: 16'h0001, er: 16'h8001};
        vecs[4] = '{l: 16'h7FFF, r: 16'hFFFF, el: 16'h7FFF, er: 16'hFFFF};
        vecs[5] = '{l: 16'h0000, r: 16'h5A5A, el: 16'h0000, er: 16'h5A5A};

        // Reset state and frame 0 waveform.
        audio_l = 16'hA5C3;
        audio_r = 16'h1234;
        reset   = 1'b1;
        repeat (3) @(negedge mclk);
        check("reset_outputs", 64'({audio_sclk, audio_lrck, audio_dac, frame_start}), 64'd0);
        reset = 1'b0;
        frame0_check("por");

        // Held pair re-sent unchanged on consecutive frames.
        for (int f = 0; f < 2; f++) begin
            capture_frame(0, 0, 16'h0, d, lr);
            check("hold_a5c3_1234_dac", d, exp_frame(ob(16'hA5C3), ob(16'h1234)));
            check("hold_a5c3_1234_lrck", lr, LrckExp);
            wait_fs(0, cap);
        end

        // Table of sample pairs; each is captured at the following frame_start.
        for (int i = 0; i < 6; i++) begin
            audio_l = vecs[i].l;
            audio_r = vecs[i].r;
            wait_fs(0, cap);
            capture_frame(0, 0, 16'h0, d, lr);
            check($sformatf("vec%0d_dac", i), d, exp_frame(ob(vecs[i].el), ob(vecs[i].er)));
            check($sformatf("vec%0d_lrck", i), lr, LrckExp);
        end

        // Input change 10 MCLK after capture only shows up a frame later.
        audio_l = 16'h0001;
        audio_r = 16'h0000;
        wait_fs(0, cap);
        capture_frame(1, 10, 16'hFFFF, d, lr);
        check("late_change_cur_frame", d, exp_frame(ob(16'h0001), ob(16'h0000)));
        wait_fs(0, cap);
        capture_frame(0, 0, 16'h0, d, lr);
        check("late_change_next_frame", d, exp_frame(ob(16'hFFFF), ob(16'h0000)));

        // Reset during bit_cnt 40 of a frame carrying R = 7FFF.
        audio_l = 16'h1234;
        audio_r = 16'h7FFF;
        wait_fs(0, cap);
        repeat (161) @(negedge mclk);
        check("mid_frame_lrck_right", 64'(audio_lrck), 64'd1);
        check("mid_frame_dac_r_bit8", 64'(audio_dac), 64'(ob(16'h7FFF) >> 8) & 64'd1);
        reset = 1'b1;
        @(negedge mclk);
        check("mid_reset_outputs", 64'({audio_sclk, audio_lrck, audio_dac, frame_start}), 64'd0);
        reset = 1'b0;
        frame0_check("mid");
        capture_frame(0, 0, 16'h0, d, lr);
        check("after_mid_reset_dac", d, exp_frame(ob(16'h1234), ob(16'h7FFF)));

        // Random left input every MCLK: decoded value equals the one captured.
        audio_r = 16'hC0DE;
        wait_fs(1, cap);
        for (int f = 0; f < 3; f++) begin
            capture_frame(2, 0, 16'h0, d, lr);
            check($sformatf("rand%0d_dac", f), d, exp_frame(ob(cap), ob(16'hC0DE)));
            wait_fs(1, cap);
        end

        check("dac_only_on_sclk_fall", 64'(dac_bad), 64'd0);
        check("frame_start_period_256", 64'(fs_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
